rc_channel_scheduler: RTL and testbench

Collects channel strobes from the F.Port receiver into a shadow bank, commits a complete frame atomically into an active bank, and serves channel reads to two consumers (motor/pose controllers) through a round-robin arbiter. Also runs the link-loss failsafe timer. Sits between `fport_radio` and all logic that consumes radio commands.

---
 rtl/rc_channel_scheduler_if.sv | 24 ++
 rtl/rc_channel_scheduler.sv | 148 ++++++++++++++
 tb/tb_rc_channel_scheduler.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rc_channel_scheduler_if.sv
// Bundle between the F.Port receiver, the channel consumers and rc_channel_scheduler.
// The scheduler attaches through the slave modport; the master side drives strobes and requests.
interface rc_channel_scheduler_if;
  logic        channel_changed;
  logic [3:0]  channel_index;
  logic [10:0] channel_value;
  logic [1:0]  req_valid;
  logic [7:0]  req_index;
  logic [1:0]  grant;
  logic        rsp_valid;
  logic [10:0] rsp_value;
  logic        failsafe;
  logic [15:0] frame_count;

  modport slave (
    input  channel_changed, channel_index, channel_value, req_valid, req_index,
    output grant, rsp_valid, rsp_value, failsafe, frame_count
  );

  modport master (
    output channel_changed, channel_index, channel_value, req_valid, req_index,
    input  grant, rsp_valid, rsp_value, failsafe, frame_count
  );
endinterface

// File: rtl/rc_channel_scheduler.sv
// Shadow/active channel banks with atomic frame commit, link-loss failsafe timer,
// and a two-requester round-robin read arbiter with a one-cycle bubble per response.
module rc_channel_scheduler #(
  parameter int unsigned clock_frequency = 12000000,
  parameter int unsigned failsafe_ms     = 100,
  parameter logic [10:0] failsafe_value  = 11'd0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  rc_channel_scheduler_if.slave bus
);

  localparam logic [31:0] FS_LIMIT = 32'(clock_frequency / 1000 * failsafe_ms);

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_RESP = 1'b1
  } arb_state_e;

  logic [10:0] shadow_q [16];
  logic [10:0] active_q [16];
  logic [31:0] fs_cnt_q, fs_cnt_d;
  logic        failsafe_q, failsafe_d;
  logic [15:0] frame_count_q, frame_count_d;
  arb_state_e  state_q;
  logic        ptr_q;
  logic [1:0]  grant_q;
  logic        rsp_valid_q;
  logic [10:0] rsp_value_q;
  logic        commit_s;
  logic        sel_s;
  logic [3:0]  rd_index_s;

  assign commit_s = bus.channel_changed && (bus.channel_index == 4'd15);

  // Channel 15 is taken from the bus so the commit never copies a stale shadow slot.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 16; i++) begin
        shadow_q[i] <= 11'd0;
        active_q[i] <= 11'd0;
      end
    end else begin
      if (bus.channel_changed) begin
        shadow_q[bus.channel_index] <= bus.channel_value;
      end
      if (commit_s) begin
        for (int i = 0; i < 15; i++) begin
          active_q[i] <= shadow_q[i];
        end
        active_q[15] <= bus.channel_value;
      end
    end
  end

  // A commit overrides the timeout even when both land on the same edge.
  always_comb begin
    fs_cnt_d      = fs_cnt_q;
    failsafe_d    = failsafe_q;
    frame_count_d = frame_count_q;
    if (commit_s) begin
      fs_cnt_d      = 32'd0;
      failsafe_d    = 1'b0;
      frame_count_d = frame_count_q + 16'd1;
    end else begin
      if (fs_cnt_q != FS_LIMIT) begin
        fs_cnt_d = fs_cnt_q + 32'd1;
      end else begin
        fs_cnt_d = fs_cnt_q;
      end
      if (fs_cnt_d == FS_LIMIT) begin
        failsafe_d = 1'b1;
      end else begin
        failsafe_d = failsafe_q;
      end
    end
  end

  // Failsafe timer and frame counter state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fs_cnt_q      <= 32'd0;
      failsafe_q    <= 1'b1;
      frame_count_q <= 16'd0;
    end else begin
      fs_cnt_q      <= fs_cnt_d;
      failsafe_q    <= failsafe_d;
      frame_count_q <= frame_count_d;
    end
  end

  // Priority pointer wins if requesting, otherwise the other requester is served.
  always_comb begin
    if (bus.req_valid[ptr_q]) begin
      sel_s = ptr_q;
    end else begin
      sel_s = ~ptr_q;
    end
    if (sel_s) begin
      rd_index_s = bus.req_index[7:4];
    end else begin
      rd_index_s = bus.req_index[3:0];
    end
  end

  // Arbiter FSM with registered grant/response outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ARB_IDLE;
      ptr_q       <= 1'b0;
      grant_q     <= 2'b00;
      rsp_valid_q <= 1'b0;
      rsp_value_q <= 11'd0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (|bus.req_valid) begin
            grant_q     <= sel_s ? 2'b10 : 2'b01;
            rsp_valid_q <= 1'b1;
            rsp_value_q <= failsafe_q ? failsafe_value : active_q[rd_index_s];
            ptr_q       <= ~sel_s;
            state_q     <= ARB_RESP;
          end else begin
            grant_q     <= 2'b00;
            rsp_valid_q <= 1'b0;
          end
        end
        ARB_RESP: begin
          grant_q     <= 2'b00;
          rsp_valid_q <= 1'b0;
          state_q     <= ARB_IDLE;
        end
        default: begin
          grant_q     <= 2'b00;
          rsp_valid_q <= 1'b0;
          state_q     <= ARB_IDLE;
        end
      endcase
    end
  end

  assign bus.grant       = grant_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_value   = rsp_value_q;
  assign bus.failsafe    = failsafe_q;
  assign bus.frame_count = frame_count_q;

endmodule

// File: tb/tb_rc_channel_scheduler.sv
// Self-checking bench for rc_channel_scheduler: directed vectors, a read table, random traffic
// against a behavioural model, and a second instance driven to frame_count wrap.
module tb_rc_channel_scheduler;

  localparam int unsigned CLK_HZ = 12000000;
  localparam int unsigned FS_MS  = 1;
  localparam logic [10:0] FV     = 11'h5A5;
  localparam int          LIMIT  = CLK_HZ / 1000 * FS_MS;

  logic clock     = 1'b0;
  logic reset_n   = 1'b1;
  logic reset_w_n = 1'b1;
  always #5 clock = ~clock;

  rc_channel_scheduler_if bus ();
  rc_channel_scheduler_if wbus ();

  rc_channel_scheduler #(.clock_frequency(CLK_HZ), .failsafe_ms(FS_MS), .failsafe_value(FV)) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus.slave));

  rc_channel_scheduler #(.clock_frequency(CLK_HZ), .failsafe_ms(FS_MS), .failsafe_value(FV)) u_wrap (
    .clock(clock), .reset_n(reset_w_n), .bus(wbus.slave));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: banks as arrays, failsafe as "cycles since last commit".
  logic [10:0] sh_m [16];
  logic [10:0] ac_m [16];
  int          frame_m, since_m, prio_m;
  bit          committed_m, bubble_m, ev;
  logic [1:0]  eg;
  logic [10:0] evalue;

  function automatic logic fs_now();
    return !committed_m || (since_m >= LIMIT);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin sh_m[i] = 11'd0; ac_m[i] = 11'd0; end
    frame_m = 0; since_m = 0; prio_m = 0;
    committed_m = 1'b0; bubble_m = 1'b0; ev = 1'b0; eg = 2'b00; evalue = 11'd0;
  endtask

  task automatic model_edge();
    logic       fs_pre;
    int         s;
    logic [3:0] idx;
    fs_pre = fs_now();
    if (bubble_m) begin
      eg = 2'b00; ev = 1'b0; bubble_m = 1'b0;
    end else if (bus.req_valid != 2'b00) begin
      s      = bus.req_valid[prio_m] ? prio_m : 1 - prio_m;
      eg     = (s == 1) ? 2'b10 : 2'b01;
      ev     = 1'b1;
      idx    = (s == 1) ? bus.req_index[7:4] : bus.req_index[3:0];
      evalue = fs_pre ? FV : ac_m[idx];
      prio_m = 1 - s;
      bubble_m = 1'b1;
    end else begin
      eg = 2'b00; ev = 1'b0;
    end
    if (bus.channel_changed && bus.channel_index == 4'd15) begin
      for (int i = 0; i < 15; i++) ac_m[i] = sh_m[i];
      ac_m[15] = bus.channel_value;
      frame_m = (frame_m + 1) % 65536;
      since_m = 0;
      committed_m = 1'b1;
    end else if (since_m < LIMIT) begin
      since_m++;
    end
    if (bus.channel_changed) sh_m[bus.channel_index] = bus.channel_value;
  endtask

  task automatic check_all();
    chk("grant", 32'(bus.grant), 32'(eg));
    chk("rsp_valid", 32'(bus.rsp_valid), 32'(ev));
    if (ev) chk("rsp_value", 32'(bus.rsp_value), 32'(evalue));
    chk("failsafe", 32'(bus.failsafe), 32'(fs_now()));
    chk("frame_count", 32'(bus.frame_count), 32'(frame_m));
  endtask

  // One clock: inputs already driven at the falling edge; compare 1 ns after the rising edge.
  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    check_all();
    @(negedge clock);
  endtask

  task automatic wr(input logic [3:0] ch, input logic [10:0] v);
    bus.channel_changed = 1'b1; bus.channel_index = ch; bus.channel_value = v;
    step();
    bus.channel_changed = 1'b0;
  endtask

  task automatic rd(input int r, input logic [3:0] ch, output logic [1:0] g, output logic [10:0] v);
    bus.req_valid[r] = 1'b1;
    if (r == 0) bus.req_index[3:0] = ch; else bus.req_index[7:4] = ch;
    step();
    g = bus.grant; v = bus.rsp_value;
    bus.req_valid[r] = 1'b0;
    step();
  endtask

  typedef struct {
    int          r;
    logic [3:0]  ch;
    logic [1:0]  exp_grant;
    logic [10:0] exp_val;
  } rd_vec_t;

  rd_vec_t     tbl [6];
  logic [1:0]  arb_g [6];
  logic [10:0] arb_v [6];
  logic [1:0]  g;
  logic [10:0] v;

  initial begin
    tbl[0] = '{0, 4'd7,  2'b01, 11'd107};
    tbl[1] = '{1, 4'd0,  2'b10, 11'd100};
    tbl[2] = '{0, 4'd15, 2'b01, 11'd115};
    tbl[3] = '{1, 4'd9,  2'b10, 11'd109};
    tbl[4] = '{1, 4'd1,  2'b10, 11'd101};
    tbl[5] = '{0, 4'd12, 2'b01, 11'd112};
    arb_g[0] = 2'b01; arb_g[1] = 2'b00; arb_g[2] = 2'b10;
    arb_g[3] = 2'b00; arb_g[4] = 2'b01; arb_g[5] = 2'b00;
    arb_v[0] = 11'd102; arb_v[1] = 11'd0; arb_v[2] = 11'd105;
    arb_v[3] = 11'd0;   arb_v[4] = 11'd102; arb_v[5] = 11'd0;

    bus.channel_changed = 1'b0; bus.channel_index = 4'd0; bus.channel_value = 11'd0;
    bus.req_valid = 2'b00; bus.req_index = 8'd0;
    wbus.channel_changed = 1'b0; wbus.channel_index = 4'd0; wbus.channel_value = 11'd0;
    wbus.req_valid = 2'b00; wbus.req_index = 8'd0;
    reset_n = 1'b0; reset_w_n = 1'b0;
    model_reset();

    fork
      begin
        repeat (2) @(negedge clock);
        chk("reset_grant", 32'(bus.grant), 32'd0);
        chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset_rsp_value", 32'(bus.rsp_value), 32'd0);
        chk("reset_failsafe", 32'(bus.failsafe), 32'd1);
        chk("reset_frame_count", 32'(bus.frame_count), 32'd0);
        reset_n = 1'b1;
        step();

        for (int i = 0; i < 16; i++) wr(4'(i), 11'(100 + i));
        chk("commit_frame_count", 32'(bus.frame_count), 32'd1);
        chk("commit_failsafe", 32'(bus.failsafe), 32'd0);

        bus.req_valid = 2'b11; bus.req_index = {4'd5, 4'd2};
        for (int k = 0; k < 6; k++) begin
          step();
          chk("arb_grant", 32'(bus.grant), 32'(arb_g[k]));
          if (arb_g[k] != 2'b00) chk("arb_value", 32'(bus.rsp_value), 32'(arb_v[k]));
        end
        bus.req_valid = 2'b00;
        step();

        for (int i = 0; i < 6; i++) begin
          rd(tbl[i].r, tbl[i].ch, g, v);
          chk("tbl_grant", 32'(g), 32'(tbl[i].exp_grant));
          chk("tbl_value", 32'(v), 32'(tbl[i].exp_val));
        end

        wr(4'd7, 11'd500);
        rd(0, 4'd7, g, v);
        chk("atomic_pre_commit", 32'(v), 32'd107);
        wr(4'd15, 11'd900);
        rd(0, 4'd7, g, v);
        chk("atomic_ch7", 32'(v), 32'd500);
        rd(1, 4'd15, g, v);
        chk("atomic_ch15", 32'(v), 32'd900);
        chk("frame_count_2", 32'(bus.frame_count), 32'd2);

        wr(4'd15, 11'd321);
        for (int k = 1; k <= LIMIT; k++) begin
          step();
          if (k == LIMIT - 1) chk("fs_before_timeout", 32'(bus.failsafe), 32'd0);
          if (k == LIMIT)     chk("fs_at_timeout", 32'(bus.failsafe), 32'd1);
        end
        rd(0, 4'd4, g, v);
        chk("fs_read_value", 32'(v), 32'(FV));
        wr(4'd15, 11'd77);
        chk("fs_cleared", 32'(bus.failsafe), 32'd0);
        chk("frame_count_4", 32'(bus.frame_count), 32'd4);
        for (int k = 1; k < LIMIT; k++) step();
        wr(4'd15, 11'd88);
        chk("fs_commit_on_timeout", 32'(bus.failsafe), 32'd0);
        rd(1, 4'd15, g, v);
        chk("fs_commit_value", 32'(v), 32'd88);

        bus.req_valid = 2'b01; bus.req_index = 8'h03;
        @(posedge clock);
        model_edge();
        #1;
        check_all();
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("midrst_grant", 32'(bus.grant), 32'd0);
        chk("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("midrst_failsafe", 32'(bus.failsafe), 32'd1);
        chk("midrst_frame_count", 32'(bus.frame_count), 32'd0);
        bus.req_valid = 2'b00;
        @(negedge clock);
        reset_n = 1'b1;
        step();
        rd(0, 4'd3, g, v);
        chk("midrst_read_ch3", 32'(v), 32'(FV));

        for (int c = 0; c < 3000; c++) begin
          bus.channel_changed = ($urandom_range(0, 3) == 0);
          bus.channel_index   = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
          bus.channel_value   = 11'($urandom_range(0, 2047));
          for (int r = 0; r < 2; r++) begin
            if (bus.req_valid[r] && eg[r]) begin
              bus.req_valid[r] = 1'b0;
            end else if (!bus.req_valid[r] && $urandom_range(0, 2) == 0) begin
              bus.req_valid[r] = 1'b1;
              if (r == 0) bus.req_index[3:0] = 4'($urandom_range(0, 15));
              else        bus.req_index[7:4] = 4'($urandom_range(0, 15));
            end
          end
          step();
        end
        bus.channel_changed = 1'b0; bus.req_valid = 2'b00;
        step();
      end
      begin
        repeat (3) @(negedge clock);
        reset_w_n = 1'b1;
        wbus.channel_changed = 1'b1; wbus.channel_index = 4'd15; wbus.channel_value = 11'd1;
        repeat (65535) @(negedge clock);
        chk("wrap_65535", 32'(wbus.frame_count), 32'd65535);
        @(negedge clock);
        chk("wrap_zero", 32'(wbus.frame_count), 32'd0);
        wbus.channel_changed = 1'b0;
        @(negedge clock);
        chk("wrap_hold", 32'(wbus.frame_count), 32'd0);
        chk("wrap_failsafe", 32'(wbus.failsafe), 32'd0);
      end
    join

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
